// File: rtl/riscv_sys_bus.sv
// riscv_sys_bus: single-outstanding system-bus interconnect between the LSU memory port and
// N_SLV memory-mapped slaves. Slave k owns the 16 MiB window selected by addr[31:24] == k.
// Unmapped addresses and slaves that miss the TIMEOUT window complete with err_o and ERR_RDATA.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_i/we_i/be_i/addr_i/wd_i  master request, sampled only while idle
//   rd_o/ready_o/err_o       completion: read data, one-cycle ready pulse, error flag
//   err_cnt_o                saturating count of error completions
//   slv_req_o                one-hot request to the selected slave
//   slv_we_o/be_o/addr_o/wd_o  latched request fields broadcast to all slaves
//   slv_rd_i/slv_ready_i     per-slave read data (32 bits each) and ready
// All outputs come straight from flops.
module riscv_sys_bus #(
  parameter int unsigned N_SLV     = 4,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wd_i,
  output logic [31:0]           rd_o,
  output logic                  ready_o,
  output logic                  err_o,
  output logic [7:0]            err_cnt_o,
  output logic [N_SLV-1:0]      slv_req_o,
  output logic                  slv_we_o,
  output logic [3:0]            slv_be_o,
  output logic [31:0]           slv_addr_o,
  output logic [31:0]           slv_wd_o,
  input  logic [32*N_SLV-1:0]   slv_rd_i,
  input  logic [N_SLV-1:0]      slv_ready_i
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone, StErr} state_e;

  state_e              state_q, state_d;
  logic [7:0]          idx_q, idx_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [31:0]         rd_q, rd_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [N_SLV-1:0]    slv_req_q, slv_req_d;
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wd_q, wd_d;

  logic                sel_ready;
  logic [31:0]         sel_rd;
  logic                mapped;

  // Only the latched index is consulted, so ready from any other slave never matters.
  always_comb begin
    sel_ready = 1'b0;
    sel_rd    = '0;
    for (int unsigned k = 0; k < N_SLV; k++) begin
      if (idx_q == 8'(k)) begin
        sel_ready = slv_ready_i[k];
        sel_rd    = slv_rd_i[32*k +: 32];
      end
    end
  end

  assign mapped = {24'd0, addr_i[31:24]} < N_SLV;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    rd_d      = rd_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    slv_req_d = slv_req_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wd_d      = wd_q;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          we_d   = we_i;
          be_d   = be_i;
          addr_d = {8'h00, addr_i[23:0]};
          wd_d   = wd_i;
          idx_d  = addr_i[31:24];
          if (mapped) begin
            state_d = StWait;
            timer_d = '0;
            for (int unsigned k = 0; k < N_SLV; k++) begin
              slv_req_d[k] = (addr_i[31:24] == 8'(k));
            end
          end else begin
            state_d   = StErr;
            ready_d   = 1'b1;
            err_d     = 1'b1;
            rd_d      = ERR_RDATA;
            err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
          end
        end
      end
      StWait: begin
        // Ready is checked before the timer so a last-cycle ready completes cleanly.
        if (sel_ready) begin
          state_d   = StDone;
          rd_d      = sel_rd;
          ready_d   = 1'b1;
          slv_req_d = '0;
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          state_d   = StErr;
          ready_d   = 1'b1;
          err_d     = 1'b1;
          rd_d      = ERR_RDATA;
          slv_req_d = '0;
          err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      timer_q   <= '0;
      rd_q      <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      slv_req_q <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      rd_q      <= rd_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      slv_req_q <= slv_req_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
    end
  end

  assign rd_o       = rd_q;
  assign ready_o    = ready_q;
  assign err_o      = err_q;
  assign err_cnt_o  = err_cnt_q;
  assign slv_req_o  = slv_req_q;
  assign slv_we_o   = we_q;
  assign slv_be_o   = be_q;
  assign slv_addr_o = addr_q;
  assign slv_wd_o   = wd_q;

endmodule

// File: tb/tb_riscv_sys_bus.sv
// Directed bench for riscv_sys_bus (N_SLV=4, TIMEOUT=16). Inputs change and outputs are
// sampled 1 time unit after each rising edge; "cycle n" matches the transaction numbering
// where cycle 0 is the idle cycle carrying req_i=1.
module tb_riscv_sys_bus;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_i;
  logic         we_i;
  logic [3:0]   be_i;
  logic [31:0]  addr_i;
  logic [31:0]  wd_i;
  logic [31:0]  rd_o;
  logic         ready_o;
  logic         err_o;
  logic [7:0]   err_cnt_o;
  logic [3:0]   slv_req_o;
  logic         slv_we_o;
  logic [3:0]   slv_be_o;
  logic [31:0]  slv_addr_o;
  logic [31:0]  slv_wd_o;
  logic [127:0] slv_rd_i;
  logic [3:0]   slv_ready_i;

  int vectors     = 0;
  int miscompares = 0;
  int pulses;

  riscv_sys_bus #(
    .N_SLV     (4),
    .TIMEOUT   (16),
    .ERR_RDATA (32'hDEAD_BEEF)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .addr_i      (addr_i),
    .wd_i        (wd_i),
    .rd_o        (rd_o),
    .ready_o     (ready_o),
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o),
    .slv_req_o   (slv_req_o),
    .slv_we_o    (slv_we_o),
    .slv_be_o    (slv_be_o),
    .slv_addr_o  (slv_addr_o),
    .slv_wd_o    (slv_wd_o),
    .slv_rd_i    (slv_rd_i),
    .slv_ready_i (slv_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".rd"},      rd_o,             32'h0);
    chk({tag, ".ready"},   {31'd0, ready_o}, 32'h0);
    chk({tag, ".err"},     {31'd0, err_o},   32'h0);
    chk({tag, ".errcnt"},  {24'd0, err_cnt_o}, 32'h0);
    chk({tag, ".slvreq"},  {28'd0, slv_req_o}, 32'h0);
    chk({tag, ".slvwe"},   {31'd0, slv_we_o}, 32'h0);
    chk({tag, ".slvbe"},   {28'd0, slv_be_o}, 32'h0);
    chk({tag, ".slvaddr"}, slv_addr_o,       32'h0);
    chk({tag, ".slvwd"},   slv_wd_o,         32'h0);
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wd_i = '0;
    slv_rd_i = '0; slv_ready_i = '0;
    step();
    step();
    rst_i = 1'b0;
    chk_reset("reset");

    // Read from slave 1, ready at k=0.
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h0100_0010;
    slv_rd_i[63:32] = 32'h1234_5678;
    step();                                           // cycle 1
    req_i = 1'b0;
    chk("rd.c1.slvreq",  {28'd0, slv_req_o}, 32'h2);
    chk("rd.c1.slvaddr", slv_addr_o, 32'h0000_0010);
    chk("rd.c1.ready",   {31'd0, ready_o}, 32'h0);
    slv_ready_i = 4'b0010;
    step();                                           // cycle 2
    slv_ready_i = 4'b0000;
    chk("rd.c2.ready",  {31'd0, ready_o}, 32'h1);
    chk("rd.c2.rd",     rd_o, 32'h1234_5678);
    chk("rd.c2.err",    {31'd0, err_o}, 32'h0);
    chk("rd.c2.slvreq", {28'd0, slv_req_o}, 32'h0);
    step();                                           // back to idle
    chk("rd.c3.ready",  {31'd0, ready_o}, 32'h0);

    // Write to slave 0 with a 3-cycle ready delay.
    req_i = 1'b1; we_i = 1'b1; be_i = 4'b0011; addr_i = 32'h0000_0004; wd_i = 32'hAABB_CCDD;
    slv_rd_i[31:0] = 32'h5555_0000;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) req_i = 1'b0;
      chk("wr.slvreq", {28'd0, slv_req_o}, 32'h1);
      chk("wr.slvwe",  {31'd0, slv_we_o}, 32'h1);
      chk("wr.slvbe",  {28'd0, slv_be_o}, 32'h3);
      chk("wr.slvwd",  slv_wd_o, 32'hAABB_CCDD);
      chk("wr.ready",  {31'd0, ready_o}, 32'h0);
      if (c == 4) slv_ready_i = 4'b0001;
    end
    step();                                           // cycle 5
    slv_ready_i = 4'b0000;
    chk("wr.c5.ready", {31'd0, ready_o}, 32'h1);
    chk("wr.c5.err",   {31'd0, err_o}, 32'h0);
    chk("wr.c5.rd",    rd_o, 32'h5555_0000);
    step();

    // Unmapped access.
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h0700_0000;
    step();                                           // cycle 1
    req_i = 1'b0;
    chk("um.c1.ready",  {31'd0, ready_o}, 32'h1);
    chk("um.c1.err",    {31'd0, err_o}, 32'h1);
    chk("um.c1.rd",     rd_o, 32'hDEAD_BEEF);
    chk("um.c1.slvreq", {28'd0, slv_req_o}, 32'h0);
    step();
    chk("um.c2.errcnt", {24'd0, err_cnt_o}, 32'h1);
    chk("um.c2.ready",  {31'd0, ready_o}, 32'h0);
    chk("um.c2.slvreq", {28'd0, slv_req_o}, 32'h0);

    // Timeout on slave 2; master inputs toggle and other slaves assert ready meanwhile.
    req_i = 1'b1; addr_i = 32'h0200_0000;
    for (int c = 1; c <= 16; c++) begin
      step();
      req_i       = (c < 16) ? c[0] : 1'b0;
      addr_i      = {8'h03, 24'(c)};
      slv_ready_i = (c < 16) ? 4'b1011 : 4'b0000;
      chk("to.slvreq",  {28'd0, slv_req_o}, 32'h4);
      chk("to.slvaddr", slv_addr_o, 32'h0);
      chk("to.ready",   {31'd0, ready_o}, 32'h0);
    end
    step();                                           // cycle 17
    chk("to.c17.ready",  {31'd0, ready_o}, 32'h1);
    chk("to.c17.err",    {31'd0, err_o}, 32'h1);
    chk("to.c17.rd",     rd_o, 32'hDEAD_BEEF);
    chk("to.c17.slvreq", {28'd0, slv_req_o}, 32'h0);
    step();
    chk("to.errcnt", {24'd0, err_cnt_o}, 32'h2);

    // Ready in the last WAIT cycle beats the timeout.
    req_i = 1'b1; addr_i = 32'h0200_0040;
    slv_rd_i[95:64] = 32'hCAFE_F00D;
    for (int c = 1; c <= 16; c++) begin
      step();
      req_i = 1'b0;
      chk("lr.slvreq", {28'd0, slv_req_o}, 32'h4);
      if (c == 16) slv_ready_i = 4'b0100;
    end
    step();                                           // cycle 17
    slv_ready_i = 4'b0000;
    chk("lr.c17.ready", {31'd0, ready_o}, 32'h1);
    chk("lr.c17.err",   {31'd0, err_o}, 32'h0);
    chk("lr.c17.rd",    rd_o, 32'hCAFE_F00D);
    step();
    chk("lr.errcnt", {24'd0, err_cnt_o}, 32'h2);

    // Reset in cycle 3 of a WAIT on slave 3.
    req_i = 1'b1; we_i = 1'b1; be_i = 4'h5; addr_i = 32'h0300_0008; wd_i = 32'h0BAD_F00D;
    step();                                           // cycle 1
    req_i = 1'b0;
    chk("rs.c1.slvaddr", slv_addr_o, 32'h0000_0008);
    step();                                           // cycle 2
    step();                                           // cycle 3
    chk("rs.c3.slvreq", {28'd0, slv_req_o}, 32'h8);
    rst_i = 1'b1;
    step();                                           // cycle 4
    rst_i = 1'b0;
    chk_reset("rs.c4");
    step();
    chk("rs.c5.slvreq", {28'd0, slv_req_o}, 32'h0);
    chk("rs.c5.ready",  {31'd0, ready_o}, 32'h0);

    // 300 back-to-back unmapped accesses saturate the error counter.
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'hFF00_0000;
    pulses = 0;
    for (int i = 1; i <= 600; i++) begin
      step();
      if (ready_o && err_o) pulses++;
      if (i == 599) req_i = 1'b0;
    end
    step();
    chk("sat.pulses", 32'(pulses), 32'd300);
    chk("sat.errcnt", {24'd0, err_cnt_o}, 32'd255);
    chk("sat.ready",  {31'd0, ready_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_sys_bus.md
# riscv_sys_bus

Parametrised system-bus interconnect between the LSU memory port and up to N_SLV memory-mapped slaves (data memory, peripherals). It decodes the top address byte and forwards one request at a time to the selected slave. It waits for that slave's ready, then returns read data and completion to the LSU. Unmapped addresses and unresponsive slaves complete with an error response, so the core never hangs.

## Interface
- N_SLV, 4, number of slave channels (1..255); slave k owns addresses k<<24 .. (k<<24)+0xFFFFFF
- TIMEOUT, 16, max WAIT cycles before timeout error (>=1)
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on any error completion
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_i  in  1  master request; held with we/be/addr/wd until ready_o
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables
- addr_i  in  32  byte address
- wd_i  in  32  write data
- rd_o  out  32  read data, valid when ready_o=1
- ready_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse with ready_o on unmapped/timeout
- err_cnt_o  out  8  saturating count of error completions
- slv_req_o  out  N_SLV  one-hot request to selected slave
- slv_we_o  out  1  latched we, broadcast
- slv_be_o  out  4  latched be, broadcast
- slv_addr_o  out  32  latched addr with [31:24] forced to 0, broadcast
- slv_wd_o  out  32  latched wd, broadcast
- slv_rd_i  in  32*N_SLV  slave k read data on bits [32k+31:32k]
- slv_ready_i  in  N_SLV  slave k ready

## Operation
- FSM states: IDLE, WAIT, DONE, ERR. Reset state IDLE.
- IDLE: when req_i=1, latch we/be/addr/wd and idx = addr_i[31:24].
  - idx < N_SLV: go to WAIT and clear the timer.
  - Otherwise: go to ERR.
- WAIT: slv_req_o[idx]=1, all other bits 0.
  - slv_ready_i[idx]=1: register slv_rd_i[idx] into rd_o and go to DONE.
  - Otherwise, timer==TIMEOUT-1: go to ERR.
  - Otherwise: timer+1.
  - Ready from a non-selected slave is ignored.
- DONE: ready_o=1, then IDLE. For writes rd_o still carries the captured slave data; the master ignores it.
- ERR: ready_o=1, err_o=1, rd_o=ERR_RDATA, err_cnt_o += 1, saturating at 255. Then IDLE.
- req_i, we_i, be_i, addr_i and wd_i are sampled only in IDLE. Changes in any other state are ignored, and the transaction runs to completion.
- A new request may be accepted in the IDLE cycle directly after DONE/ERR. There is no pipelining: at most one transaction is outstanding.
- Timer width is $clog2(TIMEOUT+1).

## Timing
- Reset values: state IDLE, rd_o=0, ready_o=0, err_o=0, err_cnt_o=0, slv_req_o=0, slv_we_o=0, slv_be_o=0, slv_addr_o=0, slv_wd_o=0, timer=0.
- Reset mid-transaction: next cycle all of the above hold, and slv_req_o drops immediately.
- All outputs are registered; none combinationally depend on inputs.
- Cycle 0 is the IDLE cycle with req_i=1.
- Mapped access:
  - slv_req_o is high from cycle 1.
  - If the slave asserts ready in cycle 1+k, ready_o is high in cycle 2+k.
  - Minimum latency is 2 (k=0).
  - slv_req_o stays high through the ready cycle and is low in the DONE cycle.
- Unmapped access: ready_o/err_o high in cycle 1. No slv_req_o is ever asserted.
- Timeout: WAIT spans cycles 1..TIMEOUT, and ready_o/err_o are high in cycle TIMEOUT+1.
- Simultaneous ready and timeout: if ready arrives in the last WAIT cycle, ready wins and the access completes normally with no error.

## Test plan
- Read, N_SLV=4: addr 0x0100_0010; slave 1 returns 0x1234_5678 with ready at k=0.
  - Required: slv_req_o=4'b0010 and slv_addr_o=0x0000_0010 in cycle 1.
  - Required: ready_o and rd_o=0x1234_5678 in cycle 2.
- Write: addr 0x0000_0004, be=4'b0011, wd=0xAABB_CCDD; slave 0 has a 3-cycle ready delay.
  - Required: slave sees we=1, be=0011, wd=0xAABB_CCDD for cycles 1..4.
  - Required: ready_o in cycle 5, err_o=0.
- Unmapped: addr 0x0700_0000 with N_SLV=4.
  - Required: ready_o=1, err_o=1, rd_o=0xDEAD_BEEF in cycle 1.
  - Required: slv_req_o=0 throughout, err_cnt_o=1.
- Timeout, TIMEOUT=16: slave 2 never ready → err_o in cycle 17. Repeat with ready in cycle 16 → normal completion, err_o=0.
- Reset/robustness:
  - Assert rst_i in cycle 3 of a WAIT → next cycle all outputs are at reset values.
  - Toggling req_i and addr_i during WAIT does not change slv_addr_o.
  - Ready from a non-selected slave is ignored.
  - 300 unmapped accesses → err_cnt_o=255.
